// File: rtl/fir5_sym_filter.sv
// 5-tap symmetric FIR: 4-bit signed samples in, 10-bit signed result out every clock.
// Build option FIR_PIPELINE_EN registers the three products, adding one cycle of latency.
module fir5_sym_filter #(
  parameter logic signed [3:0] C0 = -4'sd1,
  parameter logic signed [3:0] C1 = 4'sd3,
  parameter logic signed [3:0] C2 = 4'sd6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic signed [3:0] din,
  output logic signed [9:0] dout
);

  localparam int unsigned DW   = 4;
  localparam int unsigned PW   = 5;
  localparam int unsigned MW   = 9;
  localparam int unsigned OW   = 10;
  localparam int unsigned TAPS = 5;

  logic signed [DW-1:0] x_q [TAPS];
  logic signed [PW-1:0] pre_outer;
  logic signed [PW-1:0] pre_inner;
  logic signed [MW-1:0] prod_outer_d;
  logic signed [MW-1:0] prod_inner_d;
  logic signed [MW-1:0] prod_centre_d;
  logic signed [OW-1:0] dout_d;
  logic signed [OW-1:0] dout_q;

  // Mirrored taps share a multiplier through the pre-adders.
  always_comb begin
    pre_outer     = PW'(x_q[0]) + PW'(x_q[4]);
    pre_inner     = PW'(x_q[1]) + PW'(x_q[3]);
    prod_outer_d  = MW'(pre_outer) * MW'(C0);
    prod_inner_d  = MW'(pre_inner) * MW'(C1);
    prod_centre_d = MW'(x_q[2])    * MW'(C2);
  end

`ifdef FIR_PIPELINE_EN
  logic signed [MW-1:0] prod_outer_q;
  logic signed [MW-1:0] prod_inner_q;
  logic signed [MW-1:0] prod_centre_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_outer_q  <= '0;
      prod_inner_q  <= '0;
      prod_centre_q <= '0;
    end else begin
      prod_outer_q  <= prod_outer_d;
      prod_inner_q  <= prod_inner_d;
      prod_centre_q <= prod_centre_d;
    end
  end

  always_comb begin
    dout_d = OW'(prod_outer_q) + OW'(prod_inner_q) + OW'(prod_centre_q);
  end
`else
  always_comb begin
    dout_d = OW'(prod_outer_d) + OW'(prod_inner_d) + OW'(prod_centre_d);
  end
`endif

  // Sum never exceeds +/-320, so plain sign extension needs no saturation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q    <= '{default: '0};
      dout_q <= '0;
    end else begin
      x_q[0] <= din;
      x_q[1] <= x_q[0];
      x_q[2] <= x_q[1];
      x_q[3] <= x_q[2];
      x_q[4] <= x_q[3];
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_fir5_sym_filter.sv
// Self-checking bench for fir5_sym_filter: convolution scoreboard plus fixed-value checks.
// Honours FIR_PIPELINE_EN by adding one extra cycle of expected latency.
module tb_fir5_sym_filter;

`ifdef FIR_PIPELINE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic signed [3:0] din = 4'sd0;
  logic signed [9:0] dout;

  int checks = 0;
  int errors = 0;

  logic signed [9:0] sb [$];
  int hist [5];
  int coef [5] = '{-1, 3, 6, 3, -1};

  fir5_sym_filter dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .dout (dout)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Direct convolution over the samples taken since reset (hist[0] newest).
  function automatic logic signed [9:0] model_out();
    int acc = 0;
    for (int j = 0; j < 5; j++) acc += coef[j] * hist[j];
    return 10'(acc);
  endfunction

  task automatic model_reset();
    for (int j = 0; j < 5; j++) hist[j] = 0;
    sb.delete();
    repeat (LAT) sb.push_back(10'sd0);
  endtask

  // Drive one sample, queue its output, and return just after the sampling edge.
  task automatic drive(input int v);
    @(negedge clk);
    din = 4'(v);
    for (int j = 4; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = v;
    sb.push_back(model_out());
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (dout !== 10'sd0) begin
      errors++;
      $display("FAIL reset_async dout=%0d expected=0", dout);
    end
    din = 4'sd5;
    repeat (3) begin
      @(posedge clk);
      #1;
      checks++;
      if (dout !== 10'sd0) begin
        errors++;
        $display("FAIL reset_hold dout=%0d expected=0", dout);
      end
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset_midstream();
    logic signed [9:0] want;
    for (int c = 0; c < 6; c++) begin
      drive(7);
      want = sb.pop_front();
      checks++;
      if (dout !== want) begin
        errors++;
        $display("FAIL mid_prefill cyc=%0d dout=%0d expected=%0d", c, dout, want);
      end
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (dout !== 10'sd0) begin
      errors++;
      $display("FAIL mid_reset_async dout=%0d expected=0", dout);
    end
    din = -4'sd3;
    repeat (2) begin
      @(posedge clk);
      #1;
      checks++;
      if (dout !== 10'sd0) begin
        errors++;
        $display("FAIL mid_reset_hold dout=%0d expected=0", dout);
      end
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_impulse();
    logic signed [9:0] want;
    for (int c = 0; c < 10; c++) begin
      drive(c == 0 ? 1 : 0);
      want = sb.pop_front();
      checks++;
      if (dout !== want) begin
        errors++;
        $display("FAIL impulse cyc=%0d dout=%0d expected=%0d", c, dout, want);
      end
    end
  endtask

  task automatic test_step();
    logic signed [9:0] want;
    for (int c = 0; c < 10; c++) begin
      drive(7);
      want = sb.pop_front();
      checks++;
      if (dout !== want) begin
        errors++;
        $display("FAIL step cyc=%0d dout=%0d expected=%0d", c, dout, want);
      end
    end
    checks++;
    if (dout !== 10'sd70) begin
      errors++;
      $display("FAIL step_settled dout=%0d expected=70", dout);
    end
  endtask

  task automatic test_extremes();
    logic signed [9:0] want;
    for (int c = 0; c < 8; c++) begin
      drive(-8);
      want = sb.pop_front();
      checks++;
      if (dout !== want) begin
        errors++;
        $display("FAIL extreme_m8 cyc=%0d dout=%0d expected=%0d", c, dout, want);
      end
    end
    checks++;
    if (dout !== -10'sd80) begin
      errors++;
      $display("FAIL extreme_m8_settled dout=%0d expected=-80", dout);
    end
    for (int c = 0; c < 8; c++) begin
      drive(-7);
      want = sb.pop_front();
      checks++;
      if (dout !== want) begin
        errors++;
        $display("FAIL extreme_m7 cyc=%0d dout=%0d expected=%0d", c, dout, want);
      end
    end
    checks++;
    if (dout !== -10'sd70) begin
      errors++;
      $display("FAIL extreme_m7_settled dout=%0d expected=-70", dout);
    end
  endtask

  task automatic test_ramp();
    logic signed [9:0] want;
    int v;
    for (int s = 0; s < 29; s++) begin
      v = (s < 15) ? (s - 7) : (21 - s);
      repeat (4) begin
        drive(v);
        want = sb.pop_front();
        checks++;
        if (dout !== want) begin
          errors++;
          $display("FAIL ramp din=%0d dout=%0d expected=%0d", v, dout, want);
        end
      end
    end
  endtask

  task automatic test_alternation();
    logic signed [9:0] want;
    for (int i = -7; i <= 7; i++) begin
      for (int k = 0; k < 8; k++) begin
        drive(k < 4 ? i : -i);
        want = sb.pop_front();
        checks++;
        if (dout !== want) begin
          errors++;
          $display("FAIL alternation i=%0d k=%0d dout=%0d expected=%0d", i, k, dout, want);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_midstream();
    test_impulse();
    test_step();
    test_extremes();
    test_ramp();
    test_alternation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
